hc_read_arbiter: RTL
====================

Name: hc_read_arbiter

Overview:
Round-robin arbiter that shares one hc_buffers_if read-request channel among NUM_CLIENTS independent read engines. The engines are loopback-style kernels, each issuing indexed reads.
- Grants at most one read request per cycle and drives it onto the shared channel.
- Records the grantee in an in-order tag FIFO.
- Routes each read response back to the client that issued it.
- Sits between the per-kernel read sequencers and the buffer interface. Buffer responses return in request order.

Parameters:
NUM_CLIENTS, 4, number of requesting engines (2..8)
OFFSET_W, 11, width of buffer line offset
BUFID_W, 3, width of buffer index
DATA_W, 512, response data width
TAG_DEPTH, 64, max outstanding reads (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_CLIENTS  per-client read request valid
req_buf_id  in  NUM_CLIENTS*BUFID_W  per-client buffer index, client i at slice i
req_offset  in  NUM_CLIENTS*OFFSET_W  per-client line offset
req_ready  out  NUM_CLIENTS  one-hot grant; a request is accepted when valid&ready
rd_full  in  1  shared read channel full (buffer.read_full)
rd_valid  out  1  issued read request
rd_buf_id  out  BUFID_W  issued buffer index
rd_offset  out  OFFSET_W  issued offset
rsp_valid  in  1  buffer response valid (buffer.valid)
rsp_data  in  DATA_W  buffer response data
cl_rsp_valid  out  NUM_CLIENTS  one-hot routed response valid
cl_rsp_data  out  DATA_W  response data, broadcast to all clients
outstanding  out  $clog2(TAG_DEPTH)+1  reads in flight
err_orphan  out  1  sticky: response arrived with no tag outstanding

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. Reset is sampled only on the rising edge of clk.
- Reset values:
  - rd_valid=0, cl_rsp_valid=0, outstanding=0, err_orphan=0.
  - rd_buf_id, rd_offset and cl_rsp_data are 0.
  - Round-robin pointer is 0 and the tag FIFO is empty.
- Grant enable: grant_en = !rd_full && (outstanding < TAG_DEPTH).
- Grant decision:
  - The arbiter scans clients starting at ptr+1 mod NUM_CLIENTS, wrapping, and picks the first with req_valid=1.
  - req_ready is combinational and is asserted only for the winner, only when grant_en=1.
  - req_ready never has more than one bit set.
- Issue latency:
  - The accepted request appears on rd_valid/rd_buf_id/rd_offset on the next cycle (registered, 1-cycle latency).
  - rd_valid=0 in any cycle following a cycle with no grant.
- Pointer: on a grant, ptr <= winner index. With no grant, ptr holds.
- Tag FIFO:
  - On a grant, the winner index is pushed.
  - On rsp_valid, the head is popped.
  - The cycle after, cl_rsp_valid[head]=1 and cl_rsp_data=rsp_data (1-cycle registered latency).
- Simultaneous push and pop in one cycle: both take effect and outstanding is unchanged.
- Full condition: no grants while outstanding==TAG_DEPTH, even if a pop occurs in the same cycle. The pop takes effect, so a grant is possible next cycle.
- Orphan response: rsp_valid with outstanding==0 (and no pop available) is dropped, cl_rsp_valid stays 0, and err_orphan is set. err_orphan clears only on reset.
- Reset mid-operation:
  - In-flight tags are discarded.
  - Responses arriving after reset are orphans and set err_orphan.
  - Clients must also be reset.
- Clients keep req_valid, buf_id and offset stable until accepted. The arbiter does not check this.

Optional Feature:
Macro HC_RD_ARB_STATS_EN.
- Defined:
  - Adds output grant_count (NUM_CLIENTS*32): per-client 32-bit saturating grant counters, cleared on reset.
  - Adds output stall_cycles (32): a saturating counter of cycles with any req_valid but grant_en=0.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- hc_pkg holds:
  - t_client_id (logic [2:0]).
  - The HC_RD_ARB_MAX_CLIENTS=8 constant.
  - t_rd_req struct {buf_id, offset}.
- Sub-module hc_tag_fifo holds the synchronous FIFO of t_client_id with push, pop, head, count and empty.
- The arbitration and routing logic stays in hc_read_arbiter.

Test Plan:
1. Clients 0 and 2 valid continuously, ptr=0, rd_full=0 -> grants alternate 2,0,2,0. rd_valid is high each cycle after a grant. outstanding increments by 1 per cycle.
2. All 4 clients valid while rd_full is asserted for 3 cycles -> req_ready=0 and rd_valid=0 for those cycles. Granting resumes with the next client in RR order.
3. Issue offsets 10 (c1), 20 (c3), 30 (c1), then return three responses D0, D1, D2 -> cl_rsp_valid = 0b0010, 0b1000, 0b0010 with data D0, D1, D2, one cycle after each rsp_valid.
4. TAG_DEPTH=4: issue 4 reads with no responses -> 5th request stalls and outstanding=4. One response arrives -> grant occurs on the following cycle.
5. rsp_valid pulse with outstanding=0 -> no cl_rsp_valid and err_orphan=1. The flag stays 1 until reset.
6. Reset asserted with 3 reads outstanding -> next cycle outstanding=0, rd_valid=0, ptr=0. A subsequent response sets err_orphan.

Source files
------------

// File: rtl/hc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hc_pkg
//  Purpose  : Shared types and constants for the hc read arbiter slice.
//             t_client_id : index of a requesting read engine
//             t_rd_req    : buffer read request (buffer index + line offset)
//  Revision : 1.0 - initial release
// ============================================================================
package hc_pkg;

  localparam int HC_RD_ARB_MAX_CLIENTS = 8;
  localparam int HC_BUFID_W            = 3;
  localparam int HC_OFFSET_W           = 11;

  typedef logic [2:0] t_client_id;

  typedef struct packed {
    logic [HC_BUFID_W-1:0]  buf_id;
    logic [HC_OFFSET_W-1:0] offset;
  } t_rd_req;

endpackage
`default_nettype wire

// File: rtl/hc_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hc_tag_fifo
//  Purpose  : In-order FIFO of client ids. Records which client owns each
//             outstanding read so responses can be routed back in order.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             push, push_id   - enqueue a client id
//             pop             - dequeue the head (caller guarantees !empty)
//             head            - client id at the head of the queue
//             count, empty    - occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module hc_tag_fifo
  import hc_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  t_client_id             push_id,
  input  logic                   pop,
  output t_client_id             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  t_client_id     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/hc_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hc_read_arbiter
//  Purpose  : Round-robin arbiter sharing one buffer read-request channel
//             among NUM_CLIENTS read engines. Grants one request per cycle,
//             records the grantee in an in-order tag FIFO and routes each
//             in-order read response back to its issuing client.
//  Ports    : clk, reset                       - clock, sync active-high reset
//             req_valid/req_buf_id/req_offset  - per-client requests
//             req_ready                        - one-hot combinational grant
//             rd_full                          - shared channel back-pressure
//             rd_valid/rd_buf_id/rd_offset     - registered issued request
//             rsp_valid/rsp_data               - in-order buffer responses
//             cl_rsp_valid/cl_rsp_data         - routed response (1 cycle)
//             outstanding                      - reads in flight
//             err_orphan                       - sticky orphan-response flag
//  Option   : HC_RD_ARB_STATS_EN adds grant_count (per-client 32-bit
//             saturating grant counters) and stall_cycles (saturating count
//             of cycles with a pending request but grants disabled).
//  Revision : 1.0 - initial release
// ============================================================================
module hc_read_arbiter
  import hc_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int OFFSET_W    = HC_OFFSET_W,
  parameter int BUFID_W     = HC_BUFID_W,
  parameter int DATA_W      = 512,
  parameter int TAG_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  input  logic [NUM_CLIENTS*BUFID_W-1:0]  req_buf_id,
  input  logic [NUM_CLIENTS*OFFSET_W-1:0] req_offset,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic                          rd_full,
  output logic                          rd_valid,
  output logic [BUFID_W-1:0]            rd_buf_id,
  output logic [OFFSET_W-1:0]           rd_offset,
  input  logic                          rsp_valid,
  input  logic [DATA_W-1:0]             rsp_data,
  output logic [NUM_CLIENTS-1:0]        cl_rsp_valid,
  output logic [DATA_W-1:0]             cl_rsp_data,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_orphan
`ifdef HC_RD_ARB_STATS_EN
  ,
  output logic [NUM_CLIENTS*32-1:0]     grant_count,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  t_client_id        r_ptr;
  t_client_id        w_winner;
  t_client_id        w_head;
  logic              w_found;
  logic              w_grant_en;
  logic              w_grant;
  logic              w_pop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  t_rd_req           w_sel;
  t_rd_req           r_req;

  // Full is judged on the current occupancy only, so a pop in the same
  // cycle does not open a slot until the following cycle.
  assign w_grant_en = !rd_full && (w_count < CNT_W'(TAG_DEPTH));

  // Round-robin scan starting just after the last winner: first the clients
  // above the pointer, then wrap around to those at or below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = t_client_id'(i);
      end
    end
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!w_found && req_valid[i] && (i <= int'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = t_client_id'(i);
      end
    end
  end

  assign w_grant   = w_grant_en && w_found;
  assign req_ready = w_grant ? (NUM_CLIENTS'(1) << w_winner) : '0;

  // Request mux with constant slices per client.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (t_client_id'(i) == w_winner) begin
        w_sel.buf_id = HC_BUFID_W'(req_buf_id[i*BUFID_W +: BUFID_W]);
        w_sel.offset = HC_OFFSET_W'(req_offset[i*OFFSET_W +: OFFSET_W]);
      end
    end
  end

  assign w_pop = rsp_valid && !w_empty;

  hc_tag_fifo #(
    .DEPTH   (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_grant),
    .push_id (w_winner),
    .pop     (w_pop),
    .head    (w_head),
    .count   (w_count),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      rd_valid     <= 1'b0;
      r_req        <= '0;
      cl_rsp_valid <= '0;
      cl_rsp_data  <= '0;
      err_orphan   <= 1'b0;
    end else begin
      rd_valid <= w_grant;
      if (w_grant) begin
        r_ptr <= w_winner;
        r_req <= w_sel;
      end
      cl_rsp_valid <= w_pop ? (NUM_CLIENTS'(1) << w_head) : '0;
      if (w_pop) begin
        cl_rsp_data <= rsp_data;
      end
      // A response with no tag queued is dropped and flagged until reset.
      if (rsp_valid && w_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  assign rd_buf_id   = BUFID_W'(r_req.buf_id);
  assign rd_offset   = OFFSET_W'(r_req.offset);
  assign outstanding = w_count;

`ifdef HC_RD_ARB_STATS_EN
  logic [31:0] r_grant_cnt [NUM_CLIENTS];
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_grant_cnt[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (req_ready[i] && (r_grant_cnt[i] != '1)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
      end
      if ((|req_valid) && !w_grant_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_grant_count
    assign grant_count[g*32 +: 32] = r_grant_cnt[g];
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire
